// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared types and defaults for the SDRAM request scheduler
package sdram_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;
  function automatic int gid_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sdram_req_scheduler_rr_pick.sv
// rr_pick: first requesting index after last, wrapping around
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // scan from farthest to nearest so the nearest candidate after last wins
  always_comb begin
    found = |req;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last) + k) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/sdram_req_scheduler.sv
// sdram_req_scheduler: round-robin sharing of one SDRAM controller port with bounded grant hold
module sdram_req_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = 8,
  localparam int GW = gid_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*ADDR_W-1:0] req_address,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  input  logic [N_REQ-1:0]        req_in_valid,
  input  logic [N_REQ-1:0]        req_prefetch_step,
  output logic [N_REQ-1:0]        req_busy,
  output logic [DATA_W-1:0]       req_rdata,
  output logic [N_REQ-1:0]        req_out_valid,
  output logic [ADDR_W-1:0]       controller_address,
  output logic                    controller_rw,
  output logic [DATA_W-1:0]       data_to_controller,
  input  logic [DATA_W-1:0]       data_from_controller,
  input  logic                    controller_busy,
  output logic                    controller_in_valid,
  input  logic                    controller_out_valid,
  output logic                    controller_prefetch_step,
  output logic                    grant_valid,
  output logic [GW-1:0]           grant_id,
  output logic                    sched_err
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t          state;
  logic [GW-1:0]   last_grant, pick;
  logic [HW-1:0]   hold_cnt;
  logic            found, accept, rd_done;
  logic [N_REQ-1:0] g_hot;
  rr_pick #(.N(N_REQ), .W(GW)) u_pick (.req(req_in_valid), .last(last_grant), .found(found), .idx(pick));
  assign g_hot = N_REQ'(1) << grant_id;
  assign grant_valid = state != IDLE;
  assign accept = state == ISSUE && req_in_valid[grant_id] && !controller_busy;
  assign rd_done = state == WAIT_RD && controller_out_valid;
  assign req_busy = state == ISSUE ? ~g_hot | {N_REQ{controller_busy}} : '1;
  assign req_out_valid = rd_done ? g_hot : '0;
  assign req_rdata = data_from_controller;
  assign controller_address = grant_valid ? req_address[grant_id*ADDR_W +: ADDR_W] : '0;
  assign controller_rw = grant_valid ? req_rw[grant_id] : 1'b0;
  assign data_to_controller = grant_valid ? req_wdata[grant_id*DATA_W +: DATA_W] : '0;
  assign controller_prefetch_step = grant_valid ? req_prefetch_step[grant_id] : 1'b0;
  assign controller_in_valid = state == ISSUE && req_in_valid[grant_id];
  // grant FSM: arbitrate in IDLE, issue up to MAX_HOLD accesses, wait out each read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      hold_cnt <= '0;
      last_grant <= GW'(N_REQ - 1);
      sched_err <= 1'b0;
    end else begin
      if (controller_out_valid && state != WAIT_RD) sched_err <= 1'b1;
      case (state)
        IDLE: if (found) begin
          grant_id <= pick;
          hold_cnt <= '0;
          state <= ISSUE;
        end
        ISSUE: if (accept) begin
          hold_cnt <= hold_cnt + 1'b1;
          if (!req_rw[grant_id]) state <= WAIT_RD;
          else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
            state <= IDLE;
            last_grant <= grant_id;
          end
        end else if (!req_in_valid[grant_id]) begin
          state <= IDLE;
          last_grant <= grant_id;
        end
        WAIT_RD: if (controller_out_valid) begin
          if (req_in_valid[grant_id] && hold_cnt < HW'(MAX_HOLD)) state <= ISSUE;
          else begin
            state <= IDLE;
            last_grant <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_req_scheduler.sv
// tb_sdram_req_scheduler: randomized requesters and controller against a grant-sequence model
module tb_sdram_req_scheduler;
  localparam int N = 4, AW = 23, DW = 32, MH = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [N*AW-1:0] req_address;
  logic [N-1:0] req_rw, req_in_valid, req_prefetch_step, req_busy, req_out_valid;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] req_rdata, data_to_controller, data_from_controller;
  logic [AW-1:0] controller_address;
  logic controller_rw, controller_busy, controller_in_valid, controller_out_valid;
  logic controller_prefetch_step, grant_valid, sched_err;
  logic [1:0] grant_id;

  sdram_req_scheduler #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req_address(req_address), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_in_valid(req_in_valid), .req_prefetch_step(req_prefetch_step), .req_busy(req_busy),
    .req_rdata(req_rdata), .req_out_valid(req_out_valid), .controller_address(controller_address),
    .controller_rw(controller_rw), .data_to_controller(data_to_controller),
    .data_from_controller(data_from_controller), .controller_busy(controller_busy),
    .controller_in_valid(controller_in_valid), .controller_out_valid(controller_out_valid),
    .controller_prefetch_step(controller_prefetch_step), .grant_valid(grant_valid),
    .grant_id(grant_id), .sched_err(sched_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int rem[N], seq[N];
  logic cur_rw[N];
  logic [DW-1:0] cur_wd[N];
  int owner, cnt, last, rw_mode, rd_timer, rd_owner, busy_force, mm_at, acc_total, ph_cyc, acc_cyc;
  bit rd_pend, pulse_now, pulse_arm, stray, err_exp, force_dead, rand_busy;
  logic [DW-1:0] rd_val, last_rd;
  int olog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic pf_of(input int i);
    return seq[i][0] ^ i[0];
  endfunction

  // round-robin rule: first requester after the last owner that still has work
  function automatic int pick();
    for (int k = 1; k <= N; k++) if (rem[(last + k) % N] > 0) return (last + k) % N;
    return -1;
  endfunction

  function automatic int pending();
    int s = int'(rd_pend);
    for (int k = 0; k < N; k++) s += rem[k];
    return s;
  endfunction

  task automatic new_req(input int i);
    cur_rw[i] = rw_mode == 1 ? 1'b1 : rw_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    cur_wd[i] = $urandom;
  endtask

  task automatic set_rem(input int i, input int n);
    rem[i] = n;
    new_req(i);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) rem[k] = 0;
    owner = -1; cnt = 0; last = N - 1; rd_pend = 0; err_exp = 0; pulse_now = 0; pulse_arm = 0;
    stray = 0; busy_force = 0; mm_at = -1; force_dead = 0; rand_busy = 1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_in_valid[i] = rem[i] > 0;
      req_address[i*AW +: AW] = {4'd0, 3'(i), 16'(seq[i])};
      req_rw[i] = cur_rw[i];
      req_wdata[i*DW +: DW] = cur_wd[i];
      req_prefetch_step[i] = pf_of(i);
    end
    if (pulse_now) begin
      req_in_valid[0] = 1'b1;
      req_rw[0] = 1'b0;
    end
    controller_busy = busy_force > 0 || (rand_busy && $urandom_range(0, 3) == 0);
    controller_out_valid = stray || (rd_pend && rd_timer == 0);
    data_from_controller = (rd_pend && rd_timer == 0) ? rd_val : 32'h0BAD0BAD;
  endtask

  task automatic chk_reset();
    chk("rst_busy", req_busy, 4'hf);
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_civ", controller_in_valid, 0);
    chk("rst_ov", req_out_valid, 0);
    chk("rst_err", sched_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    drive();
    #1 chk_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // one clock: drive, check at negedge, then advance requesters/controller/model
  task automatic cycle();
    logic [N-1:0] gh, nb, exp_ov;
    logic acc, resp;
    int o;
    drive();
    @(negedge clk);
    gh = N'(1) << grant_id;
    nb = ~req_busy & ~gh;
    chk("busy_excl", nb, 0);
    if (controller_busy) chk("busy_stall", req_busy, 4'hf);
    if (!grant_valid) chk("idle_addr", controller_address, 0);
    resp = rd_pend && rd_timer == 0;
    exp_ov = resp ? N'(1) << rd_owner : '0;
    chk("out_valid", req_out_valid, exp_ov);
    if (resp) begin
      chk("rdata", req_rdata, rd_val);
      last_rd = req_rdata;
    end
    chk("sched_err", sched_err, err_exp);
    if (pulse_now) chk("pulse_busy", req_busy[0], 1'b1);
    acc = controller_in_valid && !controller_busy;
    o = -1;
    if (acc) begin
      if (owner < 0) begin
        owner = pick();
        cnt = 0;
      end
      o = owner;
      if (olog.size() == 0) acc_cyc = ph_cyc;
      chk("owner", controller_address[18:16], 64'(o));
      chk("grant_id", grant_id, 64'(o));
      if (o >= 0) begin
        chk("seq", controller_address[15:0], 16'(seq[o]));
        chk("rw", controller_rw, cur_rw[o]);
        chk("pf", controller_prefetch_step, pf_of(o));
        if (cur_rw[o]) chk("wdata", data_to_controller, cur_wd[o]);
      end
    end
    @(posedge clk);
    #1;
    if (stray) begin
      err_exp = 1;
      stray = 0;
    end
    pulse_now = 0;
    if (busy_force > 0) busy_force--;
    if (resp) rd_pend = 0;
    else if (rd_pend) rd_timer--;
    if (o >= 0) begin
      olog.push_back(o);
      acc_total++;
      if (!cur_rw[o]) begin
        rd_pend = 1;
        rd_timer = $urandom_range(0, 3);
        rd_owner = o;
        rd_val = force_dead ? 32'hDEADBEEF : $urandom;
      end
      rem[o]--;
      seq[o]++;
      new_req(o);
      cnt++;
      if (pulse_arm && o == 3) begin
        pulse_now = 1;
        pulse_arm = 0;
      end
      if (cnt == MH || rem[o] == 0) begin
        last = o;
        owner = -1;
      end
      if (acc_total == mm_at) set_rem(2, 4);
    end
    ph_cyc++;
  endtask

  task automatic run_phase(input int budget);
    int pend;
    olog.delete();
    acc_total = 0;
    ph_cyc = 0;
    pend = pending();
    while (pend != 0 && ph_cyc < budget) begin
      cycle();
      pend = pending();
    end
    chk("phase_done", pend, 0);
    repeat (2) cycle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      seq[k] = 0;
      cur_rw[k] = 0;
      cur_wd[k] = 0;
    end
    rw_mode = 0;
    do_reset();
    // all four read once: strict 0,1,2,3 order from reset
    rw_mode = 2;
    for (int k = 0; k < N; k++) set_rem(k, 1);
    run_phase(200);
    chk("t1_n", olog.size(), 4);
    for (int k = 0; k < 4; k++) chk("t1_order", olog[k], k);
    // FIR streams writes, MM joins at access 3
    do_reset();
    rw_mode = 1;
    set_rem(1, 20);
    mm_at = 3;
    run_phase(400);
    chk("t2_n", olog.size(), 24);
    chk("t2_fir_last", olog[7], 1);
    chk("t2_mm_first", olog[8], 2);
    chk("t2_mm_last", olog[11], 2);
    chk("t2_fir_back", olog[12], 1);
    // controller busy stalls the first access
    do_reset();
    rw_mode = 1;
    rand_busy = 0;
    busy_force = 7;
    set_rem(0, 1);
    run_phase(100);
    chk("t3_acc_cyc", acc_cyc, 7);
    // CPU one-cycle pulse while QS owns the port
    do_reset();
    rw_mode = 2;
    set_rem(3, 3);
    pulse_arm = 1;
    run_phase(200);
    chk("t4_qs_n", olog.size(), 3);
    for (int k = 0; k < 3; k++) chk("t4_qs_only", olog[k], 3);
    force_dead = 1;
    set_rem(0, 1);
    run_phase(100);
    chk("t4_cpu", olog[0], 0);
    chk("t4_rdata", last_rd, 32'hDEADBEEF);
    // reset while a read is outstanding
    do_reset();
    rw_mode = 2;
    set_rem(2, 2);
    ph_cyc = 0;
    acc_total = 0;
    while (acc_total == 0 && ph_cyc < 50) cycle();
    chk("t5_started", acc_total, 1);
    do_reset();
    for (int k = 0; k < N; k++) set_rem(k, 1);
    run_phase(200);
    chk("t5_first", olog[0], 0);
    // stray read strobe while idle
    stray = 1;
    repeat (4) cycle();
    chk("t6_sticky", sched_err, 1'b1);
    do_reset();
    // randomized traffic
    rw_mode = 0;
    for (int p = 0; p < 30; p++) begin
      for (int k = 0; k < N; k++) set_rem(k, $urandom_range(0, 12));
      run_phase(2000);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
